block_ctrl: RTL and testbench

Host-side controller for one hashing block's command and readout interfaces. Accepts 23-bit command writes from the host, drives the block's `command`/`opcode` bus and toggles `async_strobe` with guaranteed setup/hold. It also drains the block's result FIFO over the serial `fifo_req`/`fifo_bit` link and presents each recovered 36-bit word as `rd_meta`/`rd_data` with valid/ready. It runs in the block's `fifo_clk` domain and sits between the host register interface and one block instance.

---
 rtl/block_pkg.sv | 47 ++++
 rtl/serial_rx36.sv | 60 ++++++
 rtl/block_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_block_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// block_pkg: constants, commit field layout and FSM state types shared by
// the block controller and its serial receiver.
package block_pkg;

  // Opcodes understood by the hashing block
  localparam int OPC_INJECT_MAX = 4;
  localparam int OPC_COMMIT     = 7;

  // Result FIFO word layout: metadata in the upper bits, data in the lower bits
  localparam int FIFO_WORD_BITS = 36;
  localparam int DATA_BITS      = 20;
  localparam int META_BITS      = 16;

  // Commit payload field positions within command[15:0]
  localparam int COMMIT_CYCLE_LSB = 0;
  localparam int COMMIT_CYCLE_MSB = 4;
  localparam int COMMIT_INJECT    = 5;
  localparam int COMMIT_SAMPLE    = 6;
  localparam int COMMIT_ID_LSB    = 8;
  localparam int COMMIT_ID_MSB    = 15;

  // Packed view of the commit payload, bit 7 is unused
  typedef struct packed {
    logic [7:0] id;
    logic       reserved;
    logic       sample;
    logic       inject;
    logic [4:0] cycle;
  } commit_fields_t;

  // Command interface states
  typedef enum logic [1:0] {
    CIDLE,
    CSETUP,
    CHOLD
  } cmd_state_e;

  // Result readout states
  typedef enum logic [2:0] {
    RIDLE,
    RREQ,
    RSHIFT,
    ROUT,
    RFLUSH
  } rd_state_e;

endpackage

// File: rtl/serial_rx36.sv
// serial_rx36: collects one 36-bit FIFO word from the LSB-first serial link.
// A start pulse arms the receiver; the next 36 cycles each capture one bit.
module serial_rx36
  import block_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      bit_in,
  output logic                      done,
  output logic [FIFO_WORD_BITS-1:0] word
);

  localparam logic [5:0] LAST_BIT = 6'(FIFO_WORD_BITS - 1);

  logic                      active_q, active_d;
  logic [5:0]                cnt_q, cnt_d;
  logic [FIFO_WORD_BITS-1:0] word_q, word_d;

  // Place each incoming bit at the current counter position; abort discards the partial word
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    if (abort) begin
      active_d = 1'b0;
      cnt_d    = '0;
      word_d   = '0;
    end else if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      word_d   = '0;
    end else if (active_q) begin
      word_d[cnt_q] = bit_in;
      if (cnt_q == LAST_BIT) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      word_q   <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
    end
  end

  assign done = active_q && (cnt_q == LAST_BIT);
  assign word = word_q;

endmodule

// File: rtl/block_ctrl.sv
// block_ctrl: host-side controller for one hashing block. Drives the command
// bus with a toggle strobe that has guaranteed setup/hold, and drains the
// block's result FIFO over the serial req/bit link into a valid/ready port.
module block_ctrl
  import block_pkg::*;
#(
  parameter int SETUP      = 2,
  parameter int HOLD       = 8,
  parameter int RST_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_opcode,
  input  logic [19:0] cmd_data,
  output logic [19:0] command,
  output logic [2:0]  opcode,
  output logic        async_strobe,
  input  logic        fifo_empty,
  input  logic        fifo_oflow,
  output logic        fifo_req,
  input  logic        fifo_bit,
  output logic        fifo_rst,
  input  logic        flush,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] rd_meta,
  output logic [19:0] rd_data,
  output logic        oflow
);

  localparam logic [7:0] SETUP_INIT = 8'(SETUP - 1);
  localparam logic [7:0] HOLD_INIT  = 8'(HOLD - 1);
  localparam logic [7:0] RST_INIT   = 8'(RST_CYCLES - 1);

  cmd_state_e           cmd_state_q, cmd_state_d;
  logic [7:0]           cmd_cnt_q, cmd_cnt_d;
  logic [DATA_BITS-1:0] command_q, command_d;
  logic [2:0]           opcode_q, opcode_d;
  logic                 strobe_q, strobe_d;

  rd_state_e            rd_state_q, rd_state_d;
  logic [7:0]           rst_cnt_q, rst_cnt_d;
  logic                 oflow_q, oflow_d;

  logic                      rx_start;
  logic                      rx_done;
  logic [FIFO_WORD_BITS-1:0] rx_word;

  // Command handshake: latch the bus on acceptance, count setup, toggle once, then count hold
  always_comb begin
    cmd_state_d = cmd_state_q;
    cmd_cnt_d   = cmd_cnt_q;
    command_d   = command_q;
    opcode_d    = opcode_q;
    strobe_d    = strobe_q;
    unique case (cmd_state_q)
      CIDLE: begin
        if (cmd_valid) begin
          command_d   = cmd_data;
          opcode_d    = cmd_opcode;
          cmd_cnt_d   = SETUP_INIT;
          cmd_state_d = CSETUP;
        end
      end
      CSETUP: begin
        if (cmd_cnt_q == 8'd0) begin
          strobe_d    = ~strobe_q;
          cmd_cnt_d   = HOLD_INIT;
          cmd_state_d = CHOLD;
        end else begin
          cmd_cnt_d = cmd_cnt_q - 8'd1;
        end
      end
      CHOLD: begin
        if (cmd_cnt_q == 8'd0) begin
          cmd_state_d = CIDLE;
        end else begin
          cmd_cnt_d = cmd_cnt_q - 8'd1;
        end
      end
      default: cmd_state_d = CIDLE;
    endcase
  end

  // Command state register; reset abandons any command in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_state_q <= CIDLE;
      cmd_cnt_q   <= '0;
      command_q   <= '0;
      opcode_q    <= '0;
      strobe_q    <= 1'b0;
    end else begin
      cmd_state_q <= cmd_state_d;
      cmd_cnt_q   <= cmd_cnt_d;
      command_q   <= command_d;
      opcode_q    <= opcode_d;
      strobe_q    <= strobe_d;
    end
  end

  // Readout sequencing: request, shift 36 bits, present, with flush overriding every state
  always_comb begin
    rd_state_d = rd_state_q;
    rst_cnt_d  = rst_cnt_q;
    rx_start   = 1'b0;
    if (flush) begin
      rd_state_d = RFLUSH;
      rst_cnt_d  = RST_INIT;
    end else begin
      unique case (rd_state_q)
        RIDLE: begin
          if (!fifo_empty) begin
            rd_state_d = RREQ;
          end
        end
        RREQ: begin
          rx_start   = 1'b1;
          rd_state_d = RSHIFT;
        end
        RSHIFT: begin
          if (rx_done) begin
            rd_state_d = ROUT;
          end
        end
        ROUT: begin
          if (rd_ready) begin
            rd_state_d = RIDLE;
          end
        end
        RFLUSH: begin
          if (rst_cnt_q == 8'd0) begin
            rd_state_d = RIDLE;
          end else begin
            rst_cnt_d = rst_cnt_q - 8'd1;
          end
        end
        default: rd_state_d = RIDLE;
      endcase
    end
  end

  // Sticky overflow flag; a flush in the same cycle as an overflow wins
  always_comb begin
    oflow_d = oflow_q;
    if (flush) begin
      oflow_d = 1'b0;
    end else if (fifo_oflow && (rd_state_q != RFLUSH)) begin
      oflow_d = 1'b1;
    end
  end

  // Readout state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RIDLE;
      rst_cnt_q  <= '0;
      oflow_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rst_cnt_q  <= rst_cnt_d;
      oflow_q    <= oflow_d;
    end
  end

  serial_rx36 u_rx (
    .clk    (clk),
    .rst    (rst),
    .start  (rx_start),
    .abort  (flush),
    .bit_in (fifo_bit),
    .done   (rx_done),
    .word   (rx_word)
  );

  assign cmd_ready    = (cmd_state_q == CIDLE) && !rst;
  assign command      = command_q;
  assign opcode       = opcode_q;
  assign async_strobe = strobe_q;

  assign fifo_req = (rd_state_q == RREQ);
  assign fifo_rst = rst || (rd_state_q == RFLUSH);
  assign rd_valid = (rd_state_q == ROUT);
  assign rd_meta  = rx_word[FIFO_WORD_BITS-1:DATA_BITS];
  assign rd_data  = rx_word[DATA_BITS-1:0];
  assign oflow    = oflow_q;

endmodule

// File: tb/tb_block_ctrl.sv
// tb_block_ctrl: directed-plus-random bench for block_ctrl with a
// behavioural model of the block's result FIFO and serial link.
module tb_block_ctrl;

  localparam int SETUP      = 2;
  localparam int HOLD       = 8;
  localparam int RST_CYCLES = 8;
  localparam int WAIT_LIMIT = 300;
  localparam int READ_LAT   = 37;
  localparam int READ_PER   = 39;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [19:0] cmd_data;
  logic [19:0] command;
  logic [2:0]  opcode;
  logic        async_strobe;
  logic        fifo_empty;
  logic        fifo_oflow;
  logic        fifo_req;
  logic        fifo_bit;
  logic        fifo_rst;
  logic        flush;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_meta;
  logic [19:0] rd_data;
  logic        oflow;

  int tests_run      = 0;
  int tests_failed   = 0;
  int cyc            = 0;
  int req_violations = 0;
  int req_cycles[$];

  logic [35:0] blk_q[$];
  logic [35:0] cur_word;
  int          bit_idx;
  bit          shifting;
  bit          rst_prev;

  block_ctrl #(
    .SETUP      (SETUP),
    .HOLD       (HOLD),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_data     (cmd_data),
    .command      (command),
    .opcode       (opcode),
    .async_strobe (async_strobe),
    .fifo_empty   (fifo_empty),
    .fifo_oflow   (fifo_oflow),
    .fifo_req     (fifo_req),
    .fifo_bit     (fifo_bit),
    .fifo_rst     (fifo_rst),
    .flush        (flush),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_meta      (rd_meta),
    .rd_data      (rd_data),
    .oflow        (oflow)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle number: cycle N is the interval following the Nth rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Block-side model: FWFT FIFO popped on req, then 36 bits LSB first, cleared by fifo_rst
  initial begin
    fifo_empty = 1'b1;
    fifo_bit   = 1'b0;
    shifting   = 1'b0;
    rst_prev   = 1'b0;
    bit_idx    = 0;
    cur_word   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (fifo_req && (fifo_rst || rst_prev)) req_violations++;
      if (fifo_rst) begin
        blk_q.delete();
        shifting = 1'b0;
      end else if (shifting) begin
        fifo_bit = cur_word[bit_idx];
        bit_idx++;
        if (bit_idx == 36) shifting = 1'b0;
      end
      if (fifo_req) begin
        req_cycles.push_back(cyc);
        if (blk_q.size() > 0) cur_word = blk_q.pop_front();
        else cur_word = '0;
        shifting = !fifo_rst;
        bit_idx  = 0;
      end
      rst_prev   = fifo_rst;
      fifo_empty = (blk_q.size() == 0);
    end
  end

  // One comparison: count it and report any difference
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one command at a ready cycle and check bus, strobe and ready through its whole period
  task automatic applyStimulus(input logic [19:0] data, input logic [2:0] opc);
    logic s0;
    s0 = async_strobe;
    checkOutput("cmd_ready_at_issue", {63'd0, cmd_ready}, 64'd1);
    cmd_valid  = 1'b1;
    cmd_data   = data;
    cmd_opcode = opc;
    for (int i = 1; i <= SETUP + HOLD + 1; i++) begin
      @(negedge clk);
      cmd_data   = 20'($urandom);
      cmd_opcode = 3'($urandom);
      checkOutput("command_bus", {44'd0, command}, {44'd0, data});
      checkOutput("opcode_bus", {61'd0, opcode}, {61'd0, opc});
      checkOutput("strobe", {63'd0, async_strobe}, {63'd0, ((i >= SETUP + 1) ? ~s0 : s0)});
      checkOutput("cmd_ready", {63'd0, cmd_ready}, {63'd0, (i == SETUP + HOLD + 1)});
    end
  endtask

  // Wait at negedges for rd_valid, bounded
  task automatic waitValid(output int vcyc, output logic ok);
    ok   = 1'b0;
    vcyc = -1;
    for (int i = 0; i < WAIT_LIMIT && !ok; i++) begin
      if (rd_valid === 1'b1) begin
        ok   = 1'b1;
        vcyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // Wait at negedges until a new fifo_req has been recorded, bounded
  task automatic waitReq(input int base, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < WAIT_LIMIT && !ok; i++) begin
      if (req_cycles.size() > base) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  function automatic int lastReq();
    if (req_cycles.size() == 0) return -1000;
    return req_cycles[req_cycles.size() - 1];
  endfunction

  // Directed sequence with randomized payloads
  initial begin
    int          base;
    int          vcyc;
    int          t;
    int          acc;
    logic        ok;
    logic [2:0]  opc;
    logic [35:0] w;
    logic [35:0] exp_q[$];

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_data   = '0;
    fifo_oflow = 1'b0;
    flush      = 1'b0;
    rd_ready   = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    checkOutput("rst_fifo_rst", {63'd0, fifo_rst}, 64'd1);
    checkOutput("rst_outputs", {37'd0, command, opcode, async_strobe, fifo_req, rd_valid, oflow}, 64'd0);
    checkOutput("rst_rd_word", {28'd0, rd_meta, rd_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    checkOutput("post_rst_fifo_rst", {63'd0, fifo_rst}, 64'd0);

    applyStimulus(20'h0A5A5, 3'd3);
    applyStimulus(20'h5A5A5, 3'd7);
    repeat (4) begin
      opc = 3'($urandom_range(0, 5));
      if (opc == 3'd5) opc = 3'd7;
      applyStimulus(20'($urandom), opc);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    base = req_cycles.size();
    blk_q.push_back(36'h9_1234_5678);
    waitValid(vcyc, ok);
    checkOutput("rd1_timeout", {63'd0, ok}, 64'd1);
    checkOutput("rd1_req_count", 64'(req_cycles.size() - base), 64'd1);
    checkOutput("rd1_latency", 64'(vcyc - lastReq()), 64'(READ_LAT));
    checkOutput("rd1_meta", {48'd0, rd_meta}, 64'h9123);
    checkOutput("rd1_data", {44'd0, rd_data}, 64'h45678);

    w = 36'($urandom) ^ (36'($urandom) << 16);
    blk_q.push_back(w);
    repeat (50) begin
      @(negedge clk);
      checkOutput("hold_word", {27'd0, rd_valid, rd_meta, rd_data}, {27'd0, 1'b1, 36'h9_1234_5678});
    end
    checkOutput("hold_no_req", 64'(req_cycles.size() - base), 64'd1);
    rd_ready = 1'b1;
    acc = cyc;
    @(negedge clk);
    checkOutput("rd_valid_drop", {63'd0, rd_valid}, 64'd0);
    waitValid(vcyc, ok);
    checkOutput("rd2_timeout", {63'd0, ok}, 64'd1);
    checkOutput("rd2_req_cycle", 64'(lastReq() - acc), 64'd2);
    checkOutput("rd2_latency", 64'(vcyc - lastReq()), 64'(READ_LAT));
    checkOutput("rd2_word", {28'd0, rd_meta, rd_data}, {28'd0, w});

    for (int k = 0; k < 4; k++) begin
      w = 36'($urandom) ^ (36'($urandom) << 16);
      blk_q.push_back(w);
      exp_q.push_back(w);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      waitValid(vcyc, ok);
      checkOutput("stream_timeout", {63'd0, ok}, 64'd1);
      w = exp_q.pop_front();
      checkOutput("stream_meta", {48'd0, rd_meta}, {48'd0, w[35:20]});
      checkOutput("stream_data", {44'd0, rd_data}, {44'd0, w[19:0]});
      checkOutput("stream_period", 64'(lastReq() - req_cycles[req_cycles.size() - 2]), 64'(READ_PER));
    end

    @(negedge clk);
    fifo_oflow = 1'b1;
    @(negedge clk);
    fifo_oflow = 1'b0;
    checkOutput("oflow_set", {63'd0, oflow}, 64'd1);
    w = 36'($urandom) ^ (36'($urandom) << 16);
    blk_q.push_back(w);
    @(negedge clk);
    waitValid(vcyc, ok);
    checkOutput("oflow_rd_word", {28'd0, rd_meta, rd_data}, {28'd0, w});
    checkOutput("oflow_sticky", {63'd0, oflow}, 64'd1);

    @(negedge clk);
    base = req_cycles.size();
    blk_q.push_back(36'hF_0F0F_0F0F);
    waitReq(base, ok);
    checkOutput("flush_req_timeout", {63'd0, ok}, 64'd1);
    t = lastReq();
    while (cyc < t + 18) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_fifo_rst", {63'd0, fifo_rst}, 64'd1);
    checkOutput("flush_rd_valid", {63'd0, rd_valid}, 64'd0);
    checkOutput("flush_oflow_clr", {63'd0, oflow}, 64'd0);
    for (int c = t + 20; c <= t + 18 + RST_CYCLES; c++) begin
      @(negedge clk);
      checkOutput("flush_rst_held", {62'd0, fifo_rst, rd_valid}, 64'd2);
    end
    w = 36'($urandom) ^ (36'($urandom) << 16);
    blk_q.push_back(w);
    @(negedge clk);
    checkOutput("flush_rst_done", {62'd0, fifo_rst, fifo_req}, 64'd0);
    base = req_cycles.size();
    waitReq(base, ok);
    checkOutput("flush_next_req", 64'(lastReq() - t), 64'(18 + RST_CYCLES + 2));
    waitValid(vcyc, ok);
    checkOutput("flush_next_word", {28'd0, rd_meta, rd_data}, {28'd0, w});

    @(negedge clk);
    fifo_oflow = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("oflow_clear_wins", {63'd0, oflow}, 64'd0);
    @(negedge clk);
    fifo_oflow = 1'b0;
    checkOutput("oflow_ignored_in_flush", {63'd0, oflow}, 64'd0);
    repeat (RST_CYCLES + 2) @(negedge clk);

    base = req_cycles.size();
    blk_q.push_back(36'h1_2345_6789);
    waitReq(base, ok);
    cmd_valid  = 1'b1;
    cmd_data   = 20'hC3C3C;
    cmd_opcode = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (SETUP + 2) @(negedge clk);
    checkOutput("pre_rst_strobe", {63'd0, async_strobe}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midhold_rst", {37'd0, command, opcode, async_strobe, cmd_ready, fifo_rst, rd_valid},
                64'd2);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_ready", {63'd0, cmd_ready}, 64'd1);
    repeat (45) @(negedge clk);
    checkOutput("midshift_rst_discard", {27'd0, rd_valid, rd_meta, rd_data}, 64'd0);
    applyStimulus(20'h00F0F, 3'd7);
    cmd_valid = 1'b0;

    checkOutput("req_during_fifo_rst", 64'(req_violations), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
